// File: rtl/sync_fifo_pkg.sv
// Shared types, defaults and width helper for sync_fifo and its RAM.
package sync_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_FIFO_SIZE  = 16;

    // Per-cycle accepted operation, encoded as {push_ok, pop_ok}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic int unsigned fifo_clog2(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Simple dual-port RAM for sync_fifo: synchronous write, asynchronous read, not reset.
module sync_fifo_mem #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AW         = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO of arbitrary depth with occupancy count, level flags and error pulses.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through output; default is registered read.
import sync_fifo_pkg::*;

module sync_fifo #(
    parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_SIZE          = DEF_FIFO_SIZE,
    parameter int unsigned ALMOST_FULL_LEVEL  = 12,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 2
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   enable,
    input  logic                                   clear,
    input  logic                                   push,
    input  logic [DATA_WIDTH-1:0]                  in_data,
    input  logic                                   pop,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [fifo_clog2(FIFO_SIZE+1)-1:0]     count,
    output logic                                   empty,
    output logic                                   full,
    output logic                                   almost_empty,
    output logic                                   almost_full,
    output logic                                   pushed_last,
    output logic                                   popped_last,
    output logic                                   overflow,
    output logic                                   underflow
);

    localparam int unsigned CW = fifo_clog2(FIFO_SIZE + 1);
    localparam int unsigned PW = fifo_clog2(FIFO_SIZE);

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  empty_q, empty_d, full_q, full_d;
    logic                  almost_empty_q, almost_empty_d, almost_full_q, almost_full_d;
    logic                  pushed_last_q, pushed_last_d, popped_last_q, popped_last_d;
    logic                  overflow_q, overflow_d, underflow_q, underflow_d;
    logic                  push_ok, pop_ok, mem_we;
    logic [DATA_WIDTH-1:0] rd_data;
    fifo_op_e              op;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_SIZE),
        .AW         (PW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

    always_comb begin
        pop_ok  = enable & pop & ~empty_q;
        push_ok = enable & push & (~full_q | pop_ok);
        op      = fifo_op_e'({push_ok, pop_ok});
        mem_we  = push_ok & ~clear & rst_n;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        case (op)
            OP_PUSH: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                count_d  = count_q + CW'(1);
            end
            OP_POP: begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                count_d  = count_q - CW'(1);
            end
            OP_BOTH: begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            default: ;
        endcase

        empty_d        = (count_d == '0);
        full_d         = (count_d == CW'(FIFO_SIZE));
        almost_empty_d = (32'(count_d) <= ALMOST_EMPTY_LEVEL);
        almost_full_d  = (32'(count_d) >= ALMOST_FULL_LEVEL);
        pushed_last_d  = (op == OP_PUSH) & full_d;
        popped_last_d  = (op == OP_POP) & empty_d;
        overflow_d     = enable & push & ~push_ok;
        underflow_d    = enable & pop & ~pop_ok;

        if (clear) begin
            wr_ptr_d       = '0;
            rd_ptr_d       = '0;
            count_d        = '0;
            empty_d        = 1'b1;
            full_d         = 1'b0;
            almost_empty_d = 1'b1;
            almost_full_d  = 1'b0;
            pushed_last_d  = 1'b0;
            popped_last_d  = 1'b0;
            overflow_d     = 1'b0;
            underflow_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            empty_q        <= 1'b1;
            full_q         <= 1'b0;
            almost_empty_q <= 1'b1;
            almost_full_q  <= 1'b0;
            pushed_last_q  <= 1'b0;
            popped_last_q  <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            empty_q        <= empty_d;
            full_q         <= full_d;
            almost_empty_q <= almost_empty_d;
            almost_full_q  <= almost_full_d;
            pushed_last_q  <= pushed_last_d;
            popped_last_q  <= popped_last_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is read straight from the RAM; the registered empty flag masks stale data.
    assign out_data = empty_q ? '0 : rd_data;
`else
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;

    always_comb begin
        out_data_d = out_data_q;
        if (clear) begin
            out_data_d = '0;
        end else if (pop_ok) begin
            out_data_d = rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q <= '0;
        end else begin
            out_data_q <= out_data_d;
        end
    end

    assign out_data = out_data_q;
`endif

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = almost_empty_q;
    assign almost_full  = almost_full_q;
    assign pushed_last  = pushed_last_q;
    assign popped_last  = popped_last_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (depth 3, almost_full 2, almost_empty 0).
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst_n, enable, clear, push, pop;
    logic [7:0] in_data;
    logic [7:0] out_data;
    logic [1:0] count;
    logic       empty, full, almost_empty, almost_full;
    logic       pushed_last, popped_last, overflow, underflow;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    sync_fifo #(
        .DATA_WIDTH         (8),
        .FIFO_SIZE          (3),
        .ALMOST_FULL_LEVEL  (2),
        .ALMOST_EMPTY_LEVEL (0)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .clear        (clear),
        .push         (push),
        .in_data      (in_data),
        .pop          (pop),
        .out_data     (out_data),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .pushed_last  (pushed_last),
        .popped_last  (popped_last),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // One clock with the given request; outputs are sampled 1 time unit after the edge.
    task automatic step(input logic p, input logic [7:0] d, input logic q);
        push    = p;
        in_data = d;
        pop     = q;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
    endtask

    task automatic check_all_reset(input string tag);
        n_checks++;
        if ({out_data, count, empty, full, almost_empty, almost_full,
             pushed_last, popped_last, overflow, underflow} !== {8'h00, 2'd0, 8'b1010_0000}) begin
            n_errors++;
            $display("FAIL %s got out=%h cnt=%0d e=%b f=%b ae=%b af=%b pl=%b pp=%b ov=%b un=%b exp out=00 cnt=0 e=1 f=0 ae=1 af=0 pulses=0",
                     tag, out_data, count, empty, full, almost_empty, almost_full,
                     pushed_last, popped_last, overflow, underflow);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; clear = 1'b0;
        step(1'b0, 8'h00, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        rst_n = 1'b1;
        check_all_reset("reset_state");
    endtask

    task automatic test_basic();
        step(1'b1, 8'hAC, 1'b0);
        n_checks++;
        if (count !== 2'd1 || almost_full !== 1'b0 || almost_empty !== 1'b0) begin
            n_errors++;
            $display("FAIL push1 got cnt=%0d af=%b ae=%b exp cnt=1 af=0 ae=0", count, almost_full, almost_empty);
        end
        step(1'b1, 8'h61, 1'b0);
        n_checks++;
        if (count !== 2'd2 || almost_full !== 1'b1 || pushed_last !== 1'b0 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL push2 got cnt=%0d af=%b pl=%b f=%b exp cnt=2 af=1 pl=0 f=0", count, almost_full, pushed_last, full);
        end
        step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (out_data !== 8'hAC || count !== 2'd1) begin
            n_errors++;
            $display("FAIL pop1 got out=%h cnt=%0d exp out=ac cnt=1", out_data, count);
        end
`endif
        step(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (popped_last !== 1'b1 || empty !== 1'b1 || almost_empty !== 1'b1) begin
            n_errors++;
            $display("FAIL pop2_flags got pp=%b e=%b ae=%b exp pp=1 e=1 ae=1", popped_last, empty, almost_empty);
        end
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (out_data !== 8'h61) begin
            n_errors++;
            $display("FAIL pop2_data got %h exp 61", out_data);
        end
`endif
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (popped_last !== 1'b0) begin
            n_errors++;
            $display("FAIL popped_last_pulse got %b exp 0", popped_last);
        end
    endtask

    task automatic test_full_overflow();
        step(1'b1, 8'h11, 1'b0);
        step(1'b1, 8'h39, 1'b0);
        n_checks++;
        if (pushed_last !== 1'b0 || full !== 1'b0) begin
            n_errors++;
            $display("FAIL push_two got pl=%b f=%b exp pl=0 f=0", pushed_last, full);
        end
        step(1'b1, 8'h7D, 1'b0);
        n_checks++;
        if (pushed_last !== 1'b1 || full !== 1'b1 || count !== 2'd3) begin
            n_errors++;
            $display("FAIL push_full got pl=%b f=%b cnt=%0d exp pl=1 f=1 cnt=3", pushed_last, full, count);
        end
        step(1'b1, 8'hFF, 1'b0);
        n_checks++;
        if (overflow !== 1'b1 || count !== 2'd3 || pushed_last !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow got ov=%b cnt=%0d pl=%b exp ov=1 cnt=3 pl=0", overflow, count, pushed_last);
        end
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL overflow_pulse got %b exp 0", overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h39; exp_q[1] = 8'h7D; exp_q[2] = 8'h42;
        step(1'b1, 8'h42, 1'b1);
        n_checks++;
        if (count !== 2'd3 || overflow !== 1'b0 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL push_pop_full got cnt=%0d ov=%b f=%b exp cnt=3 ov=0 f=1", count, overflow, full);
        end
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (out_data !== 8'h11) begin
            n_errors++;
            $display("FAIL push_pop_data got %h exp 11", out_data);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
            n_checks++;
            if (out_data !== exp_q[i]) begin
                n_errors++;
                $display("FAIL wrap_pop%0d got %h exp %h", i, out_data, exp_q[i]);
            end
`endif
        end
        n_checks++;
        if (empty !== 1'b1 || popped_last !== 1'b1 || count !== 2'd0) begin
            n_errors++;
            $display("FAIL wrap_drain got e=%b pp=%b cnt=%0d exp e=1 pp=1 cnt=0", empty, popped_last, count);
        end
    endtask

    task automatic test_underflow();
        step(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (underflow !== 1'b1 || count !== 2'd0 || popped_last !== 1'b0) begin
            n_errors++;
            $display("FAIL underflow got un=%b cnt=%0d pp=%b exp un=1 cnt=0 pp=0", underflow, count, popped_last);
        end
`ifndef SYNC_FIFO_FWFT_EN
        n_checks++;
        if (out_data !== 8'h42) begin
            n_errors++;
            $display("FAIL underflow_hold got %h exp 42", out_data);
        end
`endif
        step(1'b1, 8'h5A, 1'b1);
        n_checks++;
        if (count !== 2'd1 || underflow !== 1'b1 || empty !== 1'b0) begin
            n_errors++;
            $display("FAIL push_pop_empty got cnt=%0d un=%b e=%b exp cnt=1 un=1 e=0", count, underflow, empty);
        end
        step(1'b0, 8'h00, 1'b0);
        n_checks++;
        if (underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL underflow_pulse got %b exp 0", underflow);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        step(1'b1, 8'hEE, 1'b1);
        n_checks++;
        if (count !== 2'd1 || overflow !== 1'b0 || underflow !== 1'b0) begin
            n_errors++;
            $display("FAIL disabled got cnt=%0d ov=%b un=%b exp cnt=1 ov=0 un=0", count, overflow, underflow);
        end
        enable = 1'b1;
    endtask

    task automatic test_clear_reset();
        step(1'b1, 8'h33, 1'b0);
        n_checks++;
        if (count !== 2'd2) begin
            n_errors++;
            $display("FAIL pre_clear got cnt=%0d exp 2", count);
        end
        clear = 1'b1;
        step(1'b1, 8'h44, 1'b0);
        clear = 1'b0;
        check_all_reset("clear_state");
        step(1'b1, 8'h01, 1'b0);
        step(1'b1, 8'h02, 1'b0);
        step(1'b0, 8'h00, 1'b1);
        rst_n = 1'b0;
        step(1'b1, 8'h03, 1'b0);
        rst_n = 1'b1;
        check_all_reset("midstream_reset");
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        step(1'b1, 8'hA5, 1'b0);
        n_checks++;
        if (empty !== 1'b0 || out_data !== 8'hA5) begin
            n_errors++;
            $display("FAIL fwft_show got e=%b out=%h exp e=0 out=a5", empty, out_data);
        end
        step(1'b0, 8'h00, 1'b1);
        n_checks++;
        if (empty !== 1'b1 || out_data !== 8'h00) begin
            n_errors++;
            $display("FAIL fwft_pop got e=%b out=%h exp e=1 out=00", empty, out_data);
        end
    endtask
`endif

    initial begin
        push = 1'b0; pop = 1'b0; in_data = 8'h00;
        test_reset();
        test_basic();
        test_full_overflow();
        test_back_to_back();
        test_underflow();
        test_enable();
        test_clear_reset();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
